// File: rtl/pulse_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// pulse_burst_ctrl_if
//   Burst command channel for pulse_burst_ctrl: a valid/ready handshake that
//   carries one {period, count} burst command.
//   Signals:
//     cmd_valid   master -> slave  command present
//     cmd_ready   slave -> master  slave accepts a command this cycle
//     cmd_period  master -> slave  pulse spacing in clocks (0 behaves as 1)
//     cmd_count   master -> slave  pulses in the burst (0 = empty burst)
//   PER_W / CNT_W must match the parameters of the attached pulse_burst_ctrl.
// ---------------------------------------------------------------------------
interface pulse_burst_ctrl_if #(
   parameter int PER_W = 8,
   parameter int CNT_W = 8
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [PER_W-1:0] cmd_period;
   logic [CNT_W-1:0] cmd_count;

   modport master (output cmd_valid, output cmd_period, output cmd_count, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_period, input cmd_count, output cmd_ready);
endinterface

// File: rtl/pulse_burst_ctrl.sv
// ---------------------------------------------------------------------------
// pulse_burst_ctrl
//   Command-driven sequencer for periodic single-cycle pulses. A {period,
//   count} command accepted on the cmd channel produces 'count' pulses spaced
//   'period' clocks apart; done strobes together with the last pulse, or one
//   cycle after the accept of an empty burst, or after an abort.
//   Ports:
//     clk        clock, all logic on posedge
//     reset      asynchronous active-low reset
//     cmd        pulse_burst_ctrl_if.slave command channel
//     abort      terminate the active burst (ignored while idle)
//     pulse      registered single-cycle strobe
//     done       one-cycle completion strobe
//     busy       high while a burst runs
//     remaining  pulses still to emit in the active burst
//   Build option:
//     PULSE_BURST_QUEUE_EN  adds a one-entry pending-command register so the
//                           next burst starts at the edge the current one ends.
// ---------------------------------------------------------------------------
module pulse_burst_ctrl #(
   parameter int PER_W = 8,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   pulse_burst_ctrl_if.slave    cmd,
   input  logic                 abort,
   output logic                 pulse,
   output logic                 done,
   output logic                 busy,
   output logic [CNT_W-1:0]     remaining
);

   localparam logic [PER_W-1:0] ZERO_P = {PER_W{1'b0}};
   localparam logic [PER_W-1:0] ONE_P  = {{(PER_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           state_r;
   logic [PER_W-1:0] period_r;
   logic [PER_W-1:0] cnt_r;
   logic [CNT_W-1:0] remaining_r;
   logic             pulse_r;
   logic             done_r;
   logic             busy_r;
   logic             ready_s;
   logic             accept_s;
   logic             tick_s;

   // A period of 0 is run as a period of 1.
   function automatic logic [PER_W-1:0] norm_period(input logic [PER_W-1:0] p);
      logic [PER_W-1:0] r;
      if (p == ZERO_P) r = ONE_P;
      else             r = p;
      return r;
   endfunction

   assign accept_s = cmd.cmd_valid & ready_s;
   // cnt_r never exceeds period_r-1, so equality marks the pulse edge.
   assign tick_s   = (cnt_r == (period_r - ONE_P));

`ifdef PULSE_BURST_QUEUE_EN
   logic             pend_valid_r;
   logic [PER_W-1:0] pend_period_r;
   logic [CNT_W-1:0] pend_count_r;
   logic             end_s;
   logic             nxt_valid_s;
   logic [PER_W-1:0] nxt_period_s;
   logic [CNT_W-1:0] nxt_count_s;

   assign ready_s = ~pend_valid_r;
   assign end_s   = (state_r == ST_RUN) & ~abort & tick_s & (remaining_r == ONE_C);

   // Command that takes over when the active burst ends: the held one, else one arriving at that edge.
   always_comb begin
      nxt_valid_s  = 1'b0;
      nxt_period_s = ZERO_P;
      nxt_count_s  = ZERO_C;
      if (pend_valid_r) begin
         nxt_valid_s  = 1'b1;
         nxt_period_s = pend_period_r;
         nxt_count_s  = pend_count_r;
      end else if (accept_s) begin
         nxt_valid_s  = 1'b1;
         nxt_period_s = cmd.cmd_period;
         nxt_count_s  = cmd.cmd_count;
      end else begin
         nxt_valid_s  = 1'b0;
      end
   end

   // Pending-command register: filled by an accept during a burst, emptied at burst end or abort.
   // An accept coinciding with an abort is flushed with the burst.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_valid_r  <= 1'b0;
         pend_period_r <= ZERO_P;
         pend_count_r  <= ZERO_C;
      end else if (state_r == ST_RUN) begin
         if (abort || end_s) begin
            pend_valid_r <= 1'b0;
         end else if (accept_s) begin
            pend_valid_r  <= 1'b1;
            pend_period_r <= cmd.cmd_period;
            pend_count_r  <= cmd.cmd_count;
         end else begin
            pend_valid_r <= pend_valid_r;
         end
      end else begin
         pend_valid_r <= 1'b0;
      end
   end
`else
   // busy_r is exactly (state == RUN), so ready is a registered decode.
   assign ready_s = ~busy_r;
`endif

   assign cmd.cmd_ready = ready_s;
   assign pulse         = pulse_r;
   assign done          = done_r;
   assign busy          = busy_r;
   assign remaining     = remaining_r;

   // Burst FSM with registered pulse/done/busy/remaining.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         period_r    <= ZERO_P;
         cnt_r       <= ZERO_P;
         remaining_r <= ZERO_C;
         pulse_r     <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               pulse_r <= 1'b0;
               cnt_r   <= ZERO_P;
               if (accept_s && (cmd.cmd_count != ZERO_C)) begin
                  state_r     <= ST_RUN;
                  period_r    <= norm_period(cmd.cmd_period);
                  remaining_r <= cmd.cmd_count;
                  busy_r      <= 1'b1;
                  done_r      <= 1'b0;
               end else if (accept_s) begin
                  // Empty burst: completes immediately without a pulse.
                  done_r <= 1'b1;
               end else begin
                  done_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  // Abort beats a coincident final pulse.
                  state_r     <= ST_IDLE;
                  pulse_r     <= 1'b0;
                  remaining_r <= ZERO_C;
                  cnt_r       <= ZERO_P;
                  done_r      <= 1'b1;
                  busy_r      <= 1'b0;
               end else if (tick_s) begin
                  cnt_r       <= ZERO_P;
                  pulse_r     <= 1'b1;
                  remaining_r <= remaining_r - ONE_C;
                  if (remaining_r == ONE_C) begin
                     done_r <= 1'b1;
`ifdef PULSE_BURST_QUEUE_EN
                     // Chain straight into the next burst; an empty next burst shares this done.
                     if (nxt_valid_s && (nxt_count_s != ZERO_C)) begin
                        period_r    <= norm_period(nxt_period_s);
                        remaining_r <= nxt_count_s;
                     end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                     end
`else
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
`endif
                  end else begin
                     done_r <= 1'b0;
                  end
               end else begin
                  cnt_r   <= cnt_r + ONE_P;
                  pulse_r <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= ZERO_P;
               remaining_r <= ZERO_C;
               pulse_r     <= 1'b0;
               done_r      <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

endmodule
